// File: rtl/feature_accum_recip.sv
// Foreground pixel accumulator with a bit-serial restoring reciprocal divider.
// Optional RECIP_ROUND_EN adds one extra fraction bit and rounds OnebyN half-up.
module feature_accum_recip #(
    parameter int COORD_W = 8,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pix_valid,
    input  logic               pix_fg,
    input  logic [COORD_W-1:0] pix_coord,
    input  logic               frame_end,
    input  logic               out_ready,
    output logic [15:0]        XnCn,
    output logic [16:0]        OnebyN,
    output logic [CNT_W-1:0]   count,
    output logic               out_valid,
    output logic               busy,
    output logic               ovf,
    output logic [1:0]         state_dbg
);

`ifdef RECIP_ROUND_EN
    localparam int QW = 18;
`else
    localparam int QW = 17;
`endif
    localparam int RW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [4:0]       div_cnt_q, div_cnt_d;
    logic [16:0]      recip_q, recip_d;

    logic [16:0]      sum_ext;
    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    rem_sub;
    logic             rem_ge;
    logic [QW-1:0]    quo_nx;
    logic [16:0]      recip_res;
`ifdef RECIP_ROUND_EN
    logic [QW:0]      rnd_sum;
`endif

    always_comb begin
        sum_ext = {1'b0, sum_q} + {{(17 - COORD_W){1'b0}}, pix_coord};
        // Dividend is 2^16: the single 1 enters on the first shift only.
        rem_sh  = {rem_q[RW-2:0], (div_cnt_q == 5'd0)};
        rem_ge  = (rem_sh >= {1'b0, count_q});
        rem_sub = rem_sh - {1'b0, count_q};
        quo_nx  = {quo_q[QW-2:0], rem_ge};
`ifdef RECIP_ROUND_EN
        rnd_sum = {1'b0, quo_nx} + {{QW{1'b0}}, 1'b1};
        if (rnd_sum[QW:1] > 18'h10000) begin
            recip_res = 17'h10000;
        end else begin
            recip_res = rnd_sum[17:1];
        end
`else
        recip_res = quo_nx;
`endif
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_cnt_d = div_cnt_q;
        recip_d   = recip_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    recip_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (pix_valid && pix_fg) begin
                    if (sum_ext[16]) begin
                        sum_d = 16'hFFFF;
                        ovf_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[15:0];
                    end
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (frame_end) begin
                    rem_d     = '0;
                    quo_d     = '0;
                    div_cnt_d = '0;
                    state_d   = (count_d == '0) ? S_DONE : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d     = rem_ge ? rem_sub : rem_sh;
                quo_d     = quo_nx;
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'(QW - 1)) begin
                    recip_d = recip_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= '0;
            recip_q   <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_d;
            recip_q   <= recip_d;
        end
    end

    // Handshake: a transfer happens on any edge where out_valid and out_ready are both high.
    assign XnCn      = sum_q;
    assign OnebyN    = recip_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_ACCUM) || (state_q == S_DIVIDE);
    assign state_dbg = state_q;

endmodule
